// File: rtl/qos_wrr_sched_if.sv
// Handshake bundle between the WRR scheduler and the class-FIFO / downstream datapath.
// master = scheduler side, slave = datapath side.
interface qos_wrr_sched_if;
  logic       active;
  logic [3:0] empty;
  logic       stall;
  logic [3:0] pop;
  logic [1:0] sel;
  logic       valid;
  logic [1:0] valid_sel;

  modport master (
    input  active, empty, stall,
    output pop, sel, valid, valid_sel
  );

  modport slave (
    output active, empty, stall,
    input  pop, sel, valid, valid_sel
  );
endinterface

// File: rtl/qos_wrr_sched.sv
// Weighted round-robin scheduler over four class FIFOs.
// Pops one word per cycle, follows stall/active, and keeps saturating per-class service counts.
module qos_wrr_sched #(
  parameter int WEIGHT_W = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  qos_wrr_sched_if.master     bus,
  input  logic [WEIGHT_W-1:0] weight0,
  input  logic [WEIGHT_W-1:0] weight1,
  input  logic [WEIGHT_W-1:0] weight2,
  input  logic [WEIGHT_W-1:0] weight3,
  input  logic [1:0]          cnt_idx,
  output logic [CNT_W-1:0]    cnt_out
);

  typedef enum logic [1:0] {IDLE, SERVE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cur_q, cur_d;
  logic [1:0]          last_q, last_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    svc_q [4];
  logic [CNT_W-1:0]    svc_d [4];
  logic                valid_q, valid_d;
  logic [1:0]          valid_sel_q, valid_sel_d;
  logic [3:0]          pop;
  logic                pop_en;
  logic [2:0]          search;
  logic [WEIGHT_W-1:0] weight [4];

  assign weight[0] = weight0;
  assign weight[1] = weight1;
  assign weight[2] = weight2;
  assign weight[3] = weight3;

  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  // Returns {found, index}; candidates base+1, base+2, base+3, then base itself if allowed.
  function automatic logic [2:0] rr_search(input logic [1:0] base,
                                           input logic [3:0] empty_v,
                                           input logic       incl_base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (!empty_v[idx] && ((k != 4) || incl_base)) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    pop         = '0;
    pop_en      = (state_q == SERVE) && bus.active && !bus.stall && !bus.empty[cur_q];
    pop[cur_q]  = pop_en;
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    credit_d    = credit_q;
    search      = 3'b000;
    valid_d     = |pop;
    valid_sel_d = cur_q;

    unique case (state_q)
      IDLE: begin
        if (bus.active && !bus.stall && (bus.empty != 4'hF)) begin
          search   = rr_search(last_q, bus.empty, 1'b1);
          cur_d    = search[1:0];
          credit_d = eff_weight(weight[search[1:0]]);
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (!bus.active || bus.stall) begin
          state_d = HOLD;
        end else if (bus.empty[cur_q]) begin
          last_d = cur_q;
          search = rr_search(cur_q, bus.empty, 1'b0);
          if (search[2]) begin
            cur_d    = search[1:0];
            credit_d = eff_weight(weight[search[1:0]]);
          end else begin
            credit_d = '0;
            state_d  = IDLE;
          end
        end else if (credit_q <= WEIGHT_W'(1)) begin
          // Current class still reads non-empty, so it competes as the last candidate.
          last_d = cur_q;
          search = rr_search(cur_q, bus.empty, 1'b1);
          if (search[2]) begin
            cur_d    = search[1:0];
            credit_d = eff_weight(weight[search[1:0]]);
          end else begin
            credit_d = '0;
            state_d  = IDLE;
          end
        end else begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      HOLD: begin
        if (bus.active && !bus.stall) state_d = SERVE;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < 4; i++) begin
      svc_d[i] = (pop[i] && (svc_q[i] != '1)) ? svc_q[i] + CNT_W'(1) : svc_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= 2'd0;
      last_q      <= 2'd3;
      credit_q    <= '0;
      valid_q     <= 1'b0;
      valid_sel_q <= 2'd0;
      for (int i = 0; i < 4; i++) svc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      credit_q    <= credit_d;
      valid_q     <= valid_d;
      valid_sel_q <= valid_sel_d;
      for (int i = 0; i < 4; i++) svc_q[i] <= svc_d[i];
    end
  end

  assign bus.pop       = pop;
  assign bus.sel       = cur_q;
  assign bus.valid     = valid_q;
  assign bus.valid_sel = valid_sel_q;
  assign cnt_out       = svc_q[cnt_idx];

endmodule

// File: tb/tb_qos_wrr_sched.sv
// Bench for qos_wrr_sched: directed tables and sequences, then random traffic checked
// against a cycle-level reference model that works on FIFO word counts.
module tb_qos_wrr_sched;
  localparam int WEIGHT_W = 3;
  localparam int CNT_W    = 8;
  localparam int SVC_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [WEIGHT_W-1:0] weight0, weight1, weight2, weight3;
  logic [1:0]          cnt_idx;
  logic [CNT_W-1:0]    cnt_out;

  qos_wrr_sched_if bus ();

  qos_wrr_sched #(.WEIGHT_W(WEIGHT_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .weight0 (weight0),
    .weight1 (weight1),
    .weight2 (weight2),
    .weight3 (weight3),
    .cnt_idx (cnt_idx),
    .cnt_out (cnt_out)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_SERVE, M_HOLD} mmode_t;

  typedef struct {
    bit         act;
    bit         stl;
    logic [3:0] exp_pop;
    logic [1:0] exp_sel;
    bit         exp_valid;
    logic [1:0] exp_vsel;
  } vec_t;

  int     vectors;
  int     miscompares;
  int     fifo_cnt [4];
  int     wt [4];
  vec_t   vecs [$];

  mmode_t m_mode;
  int     m_cur, m_last, m_credit, m_valid, m_vsel;
  int     m_svc [4];

  logic [3:0]       obs_pop;
  logic [1:0]       obs_sel;
  logic             obs_valid;
  logic [1:0]       obs_vsel;
  logic [CNT_W-1:0] obs_cnt;

  int zero_exp [6] = '{0, 1, 1, 1, 0, 0};
  int bp_stall [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
  int bp_pop   [9] = '{0, 0, 0, 0, 0, 0, 4, 4, 8};
  int bp_sel   [9] = '{0, 2, 2, 2, 2, 2, 2, 2, 3};

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic set_weights(input int a, input int b, input int c, input int d);
    wt[0] = a; wt[1] = b; wt[2] = c; wt[3] = d;
    weight0 = WEIGHT_W'(a);
    weight1 = WEIGHT_W'(b);
    weight2 = WEIGHT_W'(c);
    weight3 = WEIGHT_W'(d);
  endtask

  task automatic set_fifos(input int a, input int b, input int c, input int d);
    fifo_cnt[0] = a; fifo_cnt[1] = b; fifo_cnt[2] = c; fifo_cnt[3] = d;
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cur = 0; m_last = 3; m_credit = 0; m_valid = 0; m_vsel = 0;
    for (int i = 0; i < 4; i++) m_svc[i] = 0;
  endtask

  function automatic int eff_w(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit any_words();
    return (fifo_cnt[0] + fifo_cnt[1] + fifo_cnt[2] + fifo_cnt[3]) > 0;
  endfunction

  // First class holding words when walking forward from base; base itself last, if allowed.
  function automatic int rr_pick(input int base, input bit incl_base);
    int c;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4 && !incl_base) return -1;
      c = (base + k) % 4;
      if (fifo_cnt[c] > 0) return c;
    end
    return -1;
  endfunction

  function automatic int model_pop_class(input bit act, input bit stl);
    return (m_mode == M_SERVE && act && !stl && fifo_cnt[m_cur] > 0) ? m_cur : -1;
  endfunction

  task automatic give_turn(input int who);
    if (who < 0) begin
      m_mode = M_IDLE;
    end else begin
      m_cur    = who;
      m_credit = eff_w(wt[who]);
    end
  endtask

  task automatic model_advance(input bit act, input bit stl, input int pc);
    m_valid = (pc >= 0);
    m_vsel  = m_cur;
    if (pc >= 0 && m_svc[pc] < SVC_MAX) m_svc[pc]++;
    case (m_mode)
      M_IDLE: if (act && !stl && any_words()) begin
        give_turn(rr_pick(m_last, 1'b1));
        m_mode = M_SERVE;
      end
      M_SERVE: begin
        if (!act || stl) begin
          m_mode = M_HOLD;
        end else if (fifo_cnt[m_cur] == 0) begin
          m_last = m_cur;
          give_turn(rr_pick(m_cur, 1'b0));
        end else if (m_credit == 1) begin
          m_last = m_cur;
          give_turn(rr_pick(m_cur, 1'b1));
        end else begin
          m_credit--;
        end
      end
      M_HOLD: if (act && !stl) m_mode = M_SERVE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock cycle: drive inputs, sample at negedge, compare with model, advance past posedge.
  task automatic applyStimulus(input bit act, input bit stl, input int idx);
    int pc;
    int exp_pop;
    bus.active = act;
    bus.stall  = stl;
    cnt_idx    = 2'(idx);
    for (int c = 0; c < 4; c++) bus.empty[c] = (fifo_cnt[c] == 0);
    @(negedge clk);
    obs_pop   = bus.pop;
    obs_sel   = bus.sel;
    obs_valid = bus.valid;
    obs_vsel  = bus.valid_sel;
    obs_cnt   = cnt_out;
    pc      = model_pop_class(act, stl);
    exp_pop = (pc >= 0) ? (1 << pc) : 0;
    checkOutput("model_pop", int'(obs_pop), exp_pop);
    checkOutput("model_sel", int'(obs_sel), m_cur);
    checkOutput("model_valid", int'(obs_valid), m_valid);
    checkOutput("model_valid_sel", int'(obs_vsel), m_vsel);
    checkOutput("model_cnt_out", int'(obs_cnt), m_svc[idx]);
    model_advance(act, stl, pc);
    if (pc >= 0) fifo_cnt[pc]--;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    int pc;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++) bus.empty[c] = (fifo_cnt[c] == 0);
      @(negedge clk);
      pc = model_pop_class(bus.active, bus.stall);
      if (pc >= 0) fifo_cnt[pc]--;
      @(posedge clk);
      #1;
      model_reset();
    end
    reset = 1'b0;
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].act, vecs[i].stl, 0);
      checkOutput($sformatf("%s_pop[%0d]", tag, i), int'(obs_pop), int'(vecs[i].exp_pop));
      checkOutput($sformatf("%s_sel[%0d]", tag, i), int'(obs_sel), int'(vecs[i].exp_sel));
      checkOutput($sformatf("%s_valid[%0d]", tag, i), int'(obs_valid), int'(vecs[i].exp_valid));
      checkOutput($sformatf("%s_vsel[%0d]", tag, i), int'(obs_vsel), int'(vecs[i].exp_vsel));
    end
    vecs.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.active  = 1'b0;
    bus.stall   = 1'b0;
    bus.empty   = 4'hF;
    cnt_idx     = 2'd0;
    set_weights(1, 1, 1, 1);
    set_fifos(0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;

    $display("[TB] reset and idle");
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, i);
      checkOutput("idle_pop", int'(obs_pop), 0);
      checkOutput("idle_valid", int'(obs_valid), 0);
      checkOutput("idle_sel", int'(obs_sel), 0);
      checkOutput("idle_cnt", int'(obs_cnt), 0);
    end

    $display("[TB] weighted service 2,1,1,1");
    apply_reset(1);
    set_weights(2, 1, 1, 1);
    set_fifos(8, 8, 8, 8);
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd2});
    vecs.push_back('{1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd3});
    vecs.push_back('{1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd1});
    run_table("wrr");

    $display("[TB] early empty");
    apply_reset(1);
    set_weights(1, 4, 1, 2);
    set_fifos(0, 1, 0, 5);
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0});
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 2'd1});
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, 2'd1});
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd3});
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd3});
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd3});
    vecs.push_back('{1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd3});
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd3, 1'b1, 2'd3});
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, 2'd3});
    run_table("early");

    $display("[TB] zero weight, single requester");
    apply_reset(1);
    set_weights(0, 3, 3, 3);
    set_fifos(3, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 0);
      checkOutput($sformatf("zero_pop[%0d]", i), int'(obs_pop), zero_exp[i]);
    end
    checkOutput("zero_svc0", int'(obs_cnt), 3);

    $display("[TB] backpressure");
    apply_reset(1);
    set_weights(1, 1, 2, 1);
    set_fifos(0, 0, 5, 5);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, bit'(bp_stall[i]), 2);
      checkOutput($sformatf("bp_pop[%0d]", i), int'(obs_pop), bp_pop[i]);
      checkOutput($sformatf("bp_sel[%0d]", i), int'(obs_sel), bp_sel[i]);
    end

    $display("[TB] saturation and mid-op reset");
    apply_reset(1);
    set_weights(7, 1, 1, 1);
    set_fifos(400, 0, 0, 0);
    for (int i = 0; i < 301; i++) applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("sat_cnt0", int'(obs_cnt), 255);
    checkOutput("sat_pop_busy", int'(obs_pop), 1);
    apply_reset(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, i);
      if (i == 0) checkOutput("rst_pop", int'(obs_pop), 0);
      checkOutput($sformatf("rst_cnt[%0d]", i), int'(obs_cnt), 0);
    end

    $display("[TB] random traffic");
    apply_reset(1);
    set_weights($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    for (int c = 0; c < 4; c++) fifo_cnt[c] = $urandom_range(0, 5);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        int c;
        c = $urandom_range(0, 3);
        fifo_cnt[c] += $urandom_range(1, 6);
      end
      if ($urandom_range(0, 49) == 0)
        set_weights($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) apply_reset(1);
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
